// File: rtl/sik_pkg.sv
// sik_pkg: shared types, defaults and address helpers for the sik cache
package sik_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 16;
    localparam int MEMDELAY = 4;
    function automatic logic [63:0] idx_of(input logic [63:0] a, input int iw);
        return a & ((64'd1 << iw) - 64'd1);
    endfunction
    function automatic logic [63:0] tag_of(input logic [63:0] a, input int iw);
        return a >> iw;
    endfunction
endpackage

// File: rtl/sik_cache_if.sv
// sik_cache_if: processor-side and slowmem-side signals of the cache
interface sik_cache_if import sik_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cache_flush;
    logic              mem_strobe;
    logic              mem_rnotw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_mfc;
    logic [DATA_W-1:0] mem_rdata;
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cache_flush, mem_mfc, mem_rdata,
        output cpu_ack, cpu_rdata, mem_strobe, mem_rnotw, mem_addr, mem_wdata
    );
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cache_flush, mem_mfc, mem_rdata,
        input  cpu_ack, cpu_rdata, mem_strobe, mem_rnotw, mem_addr, mem_wdata
    );
endinterface

// File: rtl/sik_cache_array.sv
// sik_cache_array: direct-mapped valid/tag/data storage, async read, one write port
module sik_cache_array #(
    parameter int INDEX_W = 3,
    parameter int TAG_W   = 13,
    parameter int DATA_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_clr,
    input  logic [INDEX_W-1:0] i_rd_idx,
    output logic               o_rd_valid,
    output logic [TAG_W-1:0]   o_rd_tag,
    output logic [DATA_W-1:0]  o_rd_data,
    input  logic               i_we,
    input  logic [INDEX_W-1:0] i_wr_idx,
    input  logic [TAG_W-1:0]   i_wr_tag,
    input  logic [DATA_W-1:0]  i_wr_data
);
    localparam int LINES = 1 << INDEX_W;
    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [DATA_W-1:0] r_data [LINES];
    // valid bits: cleared by reset or flush, set by any line write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_valid <= '0;
        else if (i_clr) r_valid <= '0;
        else if (i_we) r_valid[i_wr_idx] <= 1'b1;
    end
    // tag and data need no reset; they are meaningless while the line is invalid
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end
    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];
endmodule

// File: rtl/sik_cache.sv
// sik_cache: direct-mapped write-through cache controller in front of slowmem
module sik_cache import sik_pkg::*; #(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INDEX_W = 3,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    sik_cache_if.slave       bus,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);
    localparam int TAG_W = ADDR_W - INDEX_W;
    state_t             r_state;
    logic               r_ack, r_strobe, r_rnotw;
    logic [DATA_W-1:0]  r_rdata, r_mwdata;
    logic [ADDR_W-1:0]  r_maddr;
    logic [INDEX_W-1:0] r_idx;
    logic [TAG_W-1:0]   r_tag;
    logic [CNT_W-1:0]   r_hit_cnt, r_miss_cnt;
    logic [INDEX_W-1:0] w_idx;
    logic [TAG_W-1:0]   w_tag, w_rd_tag;
    logic [DATA_W-1:0]  w_rd_data;
    logic               w_rd_valid, w_clr, w_take, w_hit, w_fill, w_we;
    assign w_idx  = INDEX_W'(idx_of(64'(bus.cpu_addr), INDEX_W));
    assign w_tag  = TAG_W'(tag_of(64'(bus.cpu_addr), INDEX_W));
    assign w_clr  = (r_state == IDLE) && bus.cache_flush;
    assign w_take = (r_state == IDLE) && !bus.cache_flush && bus.cpu_req;
    assign w_hit  = w_rd_valid && (w_rd_tag == w_tag);
    assign w_fill = (r_state == WAIT) && bus.mem_mfc;
    // stores update a resident line only; fills install the latched tag
    assign w_we   = (w_take && bus.cpu_we && w_hit) || w_fill;
    sik_cache_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_array (
        .clk        (clk),
        .reset      (reset),
        .i_clr      (w_clr),
        .i_rd_idx   (w_idx),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_we       (w_we),
        .i_wr_idx   (w_fill ? r_idx : w_idx),
        .i_wr_tag   (w_fill ? r_tag : w_tag),
        .i_wr_data  (w_fill ? bus.mem_rdata : bus.cpu_wdata)
    );
    // request FSM, registered bus outputs and saturating read counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_ack      <= 1'b0;
            r_rdata    <= '0;
            r_strobe   <= 1'b0;
            r_rnotw    <= 1'b1;
            r_maddr    <= '0;
            r_mwdata   <= '0;
            r_idx      <= '0;
            r_tag      <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_ack    <= 1'b0;
            r_strobe <= 1'b0;
            case (r_state)
                IDLE: if (w_take) begin
                    if (bus.cpu_we) begin
                        r_strobe <= 1'b1;
                        r_rnotw  <= 1'b0;
                        r_maddr  <= bus.cpu_addr;
                        r_mwdata <= bus.cpu_wdata;
                        r_ack    <= 1'b1;
                        r_state  <= RESP;
                    end else if (w_hit) begin
                        r_rdata <= w_rd_data;
                        r_ack   <= 1'b1;
                        if (~&r_hit_cnt) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
                        r_state <= RESP;
                    end else begin
                        r_strobe <= 1'b1;
                        r_rnotw  <= 1'b1;
                        r_maddr  <= bus.cpu_addr;
                        r_idx    <= w_idx;
                        r_tag    <= w_tag;
                        if (~&r_miss_cnt) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
                        r_state  <= WAIT;
                    end
                end
                WAIT: if (bus.mem_mfc) begin
                    r_rdata <= bus.mem_rdata;
                    r_ack   <= 1'b1;
                    r_state <= RESP;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.cpu_ack    = r_ack;
    assign bus.cpu_rdata  = r_rdata;
    assign bus.mem_strobe = r_strobe;
    assign bus.mem_rnotw  = r_rnotw;
    assign bus.mem_addr   = r_maddr;
    assign bus.mem_wdata  = r_mwdata;
    assign hit_count      = r_hit_cnt;
    assign miss_count     = r_miss_cnt;
endmodule
